// File: rtl/iot_ctrl_pkg.sv
// Shared constants for the interrupt / memory-extension IOT controller.
// - 600x function codes (IR[2:0]) for the interrupt group
// - 62x4 sub-codes (IR[5:3]) for the read/restore-field group
// - GTF word bit positions and a helper that assembles the GTF word
package iot_ctrl_pkg;

    typedef enum logic [2:0] {
        FnSkon = 3'd0,
        FnIon  = 3'd1,
        FnIof  = 3'd2,
        FnSrq  = 3'd3,
        FnGtf  = 3'd4,
        FnRtf  = 3'd5,
        FnSgt  = 3'd6,
        FnCaf  = 3'd7
    } fn600_e;

    typedef enum logic [2:0] {
        SubRdf = 3'd1,
        SubRif = 3'd2,
        SubRib = 3'd3,
        SubRmf = 3'd4
    } sub62x4_e;

    localparam int unsigned GtfLinkBit = 11;
    localparam int unsigned GtfIrqBit  = 9;
    localparam int unsigned GtfIiBit   = 8;
    localparam int unsigned GtfIeBit   = 7;

    // GTF: {LINK, 0, |IRQ, II, IE, 0, SF[5:0]}
    function automatic logic [11:0] gtf_word(input logic       link,
                                             input logic       irq_any,
                                             input logic       ii,
                                             input logic       ie,
                                             input logic [5:0] sf);
        logic [11:0] w;
        w             = {6'b0, sf};
        w[GtfLinkBit] = link;
        w[GtfIrqBit]  = irq_any;
        w[GtfIiBit]   = ii;
        w[GtfIeBit]   = ie;
        return w;
    endfunction

endpackage

// File: rtl/iot_int_sched.sv
// Interrupt scheduling flags: IE (enable), DELAY (ION/RTF one-instruction
// delay), II (interrupt inhibit after CIF/RTF/RMF) and the CPU INT_REQ.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   skon_i .. set_ii_i   decoded IOT commands, already qualified by DONE
//   instr_done_i         end-of-instruction pulse, jmp_jms_i qualifies it
//   int_ack_i            CPU has started the interrupt JMS
//   irq_any_i            OR of device requests
//   ie_o, ii_o           current flags
//   int_req_o            request to the CPU sequencer
module iot_int_sched (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic skon_i,
    input  logic ion_i,
    input  logic iof_i,
    input  logic caf_i,
    input  logic set_ii_i,
    input  logic instr_done_i,
    input  logic jmp_jms_i,
    input  logic int_ack_i,
    input  logic irq_any_i,
    output logic ie_o,
    output logic ii_o,
    output logic int_req_o
);

    logic ie_q, ie_d;
    logic delay_q, delay_d;
    logic ii_q, ii_d;
    logic int_req_q, int_req_d;

    // Values after the IOT effects of this cycle, before end-of-instruction
    logic ie_m, delay_m, ii_m, req_m;

    always_comb begin
        ie_m    = ie_q;
        delay_m = delay_q;
        ii_m    = ii_q;
        req_m   = int_req_q;

        if (skon_i || iof_i) begin
            ie_m = 1'b0;
        end
        if (iof_i) begin
            delay_m = 1'b0;
        end
        if (ion_i) begin
            ie_m    = 1'b1;
            delay_m = 1'b1;
        end
        if (set_ii_i) begin
            ii_m = 1'b1;
        end
        if (caf_i) begin
            ie_m    = 1'b0;
            delay_m = 1'b0;
            ii_m    = 1'b0;
            req_m   = 1'b0;
        end

        ie_d      = ie_m;
        delay_d   = delay_m;
        ii_d      = ii_m;
        int_req_d = req_m;

        if (int_ack_i) begin
            ie_d      = 1'b0;
            int_req_d = 1'b0;
        end else if (instr_done_i) begin
            // Request uses the flags as they stood before this boundary, so
            // DELAY set by ION/RTF blocks the boundary of that same instruction.
            if (ie_m && !delay_m && !ii_m && irq_any_i) begin
                int_req_d = 1'b1;
            end
            if (jmp_jms_i) begin
                ii_d = 1'b0;
            end
            delay_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ie_q      <= 1'b0;
            delay_q   <= 1'b0;
            ii_q      <= 1'b0;
            int_req_q <= 1'b0;
        end else begin
            ie_q      <= ie_d;
            delay_q   <= delay_d;
            ii_q      <= ii_d;
            int_req_q <= int_req_d;
        end
    end

    assign ie_o      = ie_q;
    assign ii_o      = ii_q;
    assign int_req_o = int_req_q;

endmodule

// File: rtl/iot_int_memext_ctrl.sv
// IOT controller for the interrupt group (600x) and memory extension (62xx).
// Holds IF/IB/DF/SF, drives registered SKIP/AC/LINK/DEV_CLR strobes one
// cycle after DONE, and hands the interrupt flags to iot_int_sched.
// Ports:
//   CLK, RESET_N               clock, async active-low reset
//   DONE, IOT600x, IOT62x1..4  decoded IOT execute strobes
//   IR, AC, LINK               datapath inputs
//   INSTR_DONE, JMP_JMS        instruction boundary
//   INT_ACK, IRQ               interrupt acknowledge / device requests
//   IF, DF                     field outputs to the address mux
//   INT_REQ, ION               interrupt status
//   SKIP, AC_LOAD, AC_OUT, LINK_LOAD, LINK_OUT, DEV_CLR  datapath strobes
module iot_int_memext_ctrl #(
    parameter int unsigned NIRQ = 4
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            DONE,
    input  logic            IOT600x,
    input  logic            IOT62x1,
    input  logic            IOT62x2,
    input  logic            IOT62x3,
    input  logic            IOT62x4,
    input  logic [11:0]     IR,
    input  logic [11:0]     AC,
    input  logic            LINK,
    input  logic            INSTR_DONE,
    input  logic            JMP_JMS,
    input  logic            INT_ACK,
    input  logic [NIRQ-1:0] IRQ,
    output logic [2:0]      IF,
    output logic [2:0]      DF,
    output logic            INT_REQ,
    output logic            ION,
    output logic            SKIP,
    output logic            AC_LOAD,
    output logic [11:0]     AC_OUT,
    output logic            LINK_LOAD,
    output logic            LINK_OUT,
    output logic            DEV_CLR
);

    import iot_ctrl_pkg::*;

    logic       irq_any;
    logic [2:0] fn;
    logic [2:0] n;
    logic       unused_ir;

    assign irq_any   = |IRQ;
    assign fn        = IR[2:0];
    assign n         = IR[5:3];
    assign unused_ir = ^IR[11:6];

    // Decoded, DONE-qualified commands
    logic do_skon, do_ion, do_iof, do_srq, do_gtf, do_rtf, do_caf;
    logic do_cdf, do_cif, do_rdf, do_rif, do_rib, do_rmf;

    always_comb begin
        do_skon = 1'b0;
        do_ion  = 1'b0;
        do_iof  = 1'b0;
        do_srq  = 1'b0;
        do_gtf  = 1'b0;
        do_rtf  = 1'b0;
        do_caf  = 1'b0;
        do_cdf  = 1'b0;
        do_cif  = 1'b0;
        do_rdf  = 1'b0;
        do_rif  = 1'b0;
        do_rib  = 1'b0;
        do_rmf  = 1'b0;
        if (DONE) begin
            if (IOT600x) begin
                unique case (fn)
                    FnSkon:  do_skon = 1'b1;
                    FnIon:   do_ion  = 1'b1;
                    FnIof:   do_iof  = 1'b1;
                    FnSrq:   do_srq  = 1'b1;
                    FnGtf:   do_gtf  = 1'b1;
                    FnRtf:   do_rtf  = 1'b1;
                    FnSgt:   ;  // never skips
                    FnCaf:   do_caf  = 1'b1;
                    default: ;
                endcase
            end else if (IOT62x1 || IOT62x2 || IOT62x3) begin
                do_cdf = IOT62x1 | IOT62x3;
                do_cif = IOT62x2 | IOT62x3;
            end else if (IOT62x4) begin
                case (n)
                    SubRdf:  do_rdf = 1'b1;
                    SubRif:  do_rif = 1'b1;
                    SubRib:  do_rib = 1'b1;
                    SubRmf:  do_rmf = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Interrupt flags
    logic ie, ii;

    iot_int_sched u_sched (
        .clk_i        (CLK),
        .rst_ni       (RESET_N),
        .skon_i       (do_skon),
        .ion_i        (do_ion | do_rtf),
        .iof_i        (do_iof),
        .caf_i        (do_caf),
        .set_ii_i     (do_cif | do_rtf | do_rmf),
        .instr_done_i (INSTR_DONE),
        .jmp_jms_i    (JMP_JMS),
        .int_ack_i    (INT_ACK),
        .irq_any_i    (irq_any),
        .ie_o         (ie),
        .ii_o         (ii),
        .int_req_o    (INT_REQ)
    );

    // Field registers
    logic [2:0] if_q, if_d;
    logic [2:0] ib_q, ib_d;
    logic [2:0] df_q, df_d;
    logic [5:0] sf_q, sf_d;
    logic [2:0] ib_m, df_m;

    always_comb begin
        ib_m = ib_q;
        df_m = df_q;
        if (do_cdf) begin
            df_m = n;
        end
        if (do_cif) begin
            ib_m = n;
        end
        if (do_rtf) begin
            ib_m = AC[5:3];
            df_m = AC[2:0];
        end
        if (do_rmf) begin
            ib_m = sf_q[5:3];
            df_m = sf_q[2:0];
        end

        if_d = if_q;
        ib_d = ib_m;
        df_d = df_m;
        sf_d = sf_q;
        if (INT_ACK) begin
            sf_d = {if_q, df_m};
            if_d = 3'd0;
            ib_d = 3'd0;
            df_d = 3'd0;
        end else if (INSTR_DONE && JMP_JMS) begin
            // IF only follows IB at a completed JMP/JMS
            if_d = ib_m;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            if_q <= 3'd0;
            ib_q <= 3'd0;
            df_q <= 3'd0;
            sf_q <= 6'd0;
        end else begin
            if_q <= if_d;
            ib_q <= ib_d;
            df_q <= df_d;
            sf_q <= sf_d;
        end
    end

    // Datapath strobes, registered so they appear the cycle after DONE
    logic        skip_q, skip_d;
    logic        ac_load_q, ac_load_d;
    logic [11:0] ac_out_q, ac_out_d;
    logic        link_load_q, link_load_d;
    logic        link_out_q, link_out_d;
    logic        dev_clr_q, dev_clr_d;

    always_comb begin
        skip_d      = (do_skon & ie) | (do_srq & irq_any);
        ac_load_d   = do_gtf | do_caf | do_rdf | do_rif | do_rib;
        link_load_d = do_rtf | do_caf;
        link_out_d  = do_rtf & AC[11];
        dev_clr_d   = do_caf;
        ac_out_d    = 12'd0;
        if (do_gtf) begin
            ac_out_d = gtf_word(LINK, irq_any, ii, ie, sf_q);
        end else if (do_rdf) begin
            ac_out_d = AC | {6'd0, df_q, 3'd0};
        end else if (do_rif) begin
            ac_out_d = AC | {6'd0, if_q, 3'd0};
        end else if (do_rib) begin
            ac_out_d = AC | {6'd0, sf_q};
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            skip_q      <= 1'b0;
            ac_load_q   <= 1'b0;
            ac_out_q    <= 12'd0;
            link_load_q <= 1'b0;
            link_out_q  <= 1'b0;
            dev_clr_q   <= 1'b0;
        end else begin
            skip_q      <= skip_d;
            ac_load_q   <= ac_load_d;
            ac_out_q    <= ac_out_d;
            link_load_q <= link_load_d;
            link_out_q  <= link_out_d;
            dev_clr_q   <= dev_clr_d;
        end
    end

    assign IF        = if_q;
    assign DF        = df_q;
    assign ION       = ie;
    assign SKIP      = skip_q;
    assign AC_LOAD   = ac_load_q;
    assign AC_OUT    = ac_out_q;
    assign LINK_LOAD = link_load_q;
    assign LINK_OUT  = link_out_q;
    assign DEV_CLR   = dev_clr_q;

endmodule

// File: tb/tb_iot_int_memext_ctrl.sv
// Directed bench: strobe responses go through a scoreboard queue checked by a
// monitor; field/flag state is checked directly after each step.
module tb_iot_int_memext_ctrl;

    localparam int unsigned NIRQ = 4;

    logic            CLK = 1'b0;
    logic            RESET_N = 1'b0;
    logic            DONE = 1'b0;
    logic            IOT600x = 1'b0;
    logic            IOT62x1 = 1'b0;
    logic            IOT62x2 = 1'b0;
    logic            IOT62x3 = 1'b0;
    logic            IOT62x4 = 1'b0;
    logic [11:0]     IR = '0;
    logic [11:0]     AC = '0;
    logic            LINK = 1'b0;
    logic            INSTR_DONE = 1'b0;
    logic            JMP_JMS = 1'b0;
    logic            INT_ACK = 1'b0;
    logic [NIRQ-1:0] IRQ = '0;
    logic [2:0]      IF, DF;
    logic            INT_REQ, ION, SKIP, AC_LOAD, LINK_LOAD, LINK_OUT, DEV_CLR;
    logic [11:0]     AC_OUT;

    iot_int_memext_ctrl #(.NIRQ(NIRQ)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .DONE       (DONE),
        .IOT600x    (IOT600x),
        .IOT62x1    (IOT62x1),
        .IOT62x2    (IOT62x2),
        .IOT62x3    (IOT62x3),
        .IOT62x4    (IOT62x4),
        .IR         (IR),
        .AC         (AC),
        .LINK       (LINK),
        .INSTR_DONE (INSTR_DONE),
        .JMP_JMS    (JMP_JMS),
        .INT_ACK    (INT_ACK),
        .IRQ        (IRQ),
        .IF         (IF),
        .DF         (DF),
        .INT_REQ    (INT_REQ),
        .ION        (ION),
        .SKIP       (SKIP),
        .AC_LOAD    (AC_LOAD),
        .AC_OUT     (AC_OUT),
        .LINK_LOAD  (LINK_LOAD),
        .LINK_OUT   (LINK_OUT),
        .DEV_CLR    (DEV_CLR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic        skip;
        logic        ac_load;
        logic [11:0] ac_out;
        logic        link_load;
        logic        link_out;
        logic        dev_clr;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    bit   pend_v = 1'b0;

    // Arm the expected strobe for the next IOT issued
    task automatic expect_strobe(input string nm, input logic sk, input logic acl,
                                 input logic [11:0] aco, input logic lkl,
                                 input logic lko, input logic dvc);
        pend.name      = nm;
        pend.skip      = sk;
        pend.ac_load   = acl;
        pend.ac_out    = aco;
        pend.link_load = lkl;
        pend.link_out  = lko;
        pend.dev_clr   = dvc;
        pend_v         = 1'b1;
    endtask

    // g: 0=600x 1=62x1 2=62x2 3=62x3 4=62x4, anything else = no group
    task automatic iot(input int g, input logic [11:0] ir, input logic [11:0] ac);
        @(negedge CLK);
        IR      = ir;
        AC      = ac;
        DONE    = 1'b1;
        IOT600x = (g == 0);
        IOT62x1 = (g == 1);
        IOT62x2 = (g == 2);
        IOT62x3 = (g == 3);
        IOT62x4 = (g == 4);
        if (pend_v) begin
            pend.cyc = cyc + 1;
            sb.push_back(pend);
            pend_v = 1'b0;
        end
        @(negedge CLK);
        DONE    = 1'b0;
        IOT600x = 1'b0;
        IOT62x1 = 1'b0;
        IOT62x2 = 1'b0;
        IOT62x3 = 1'b0;
        IOT62x4 = 1'b0;
    endtask

    task automatic idone(input logic jmp);
        @(negedge CLK);
        INSTR_DONE = 1'b1;
        JMP_JMS    = jmp;
        @(negedge CLK);
        INSTR_DONE = 1'b0;
        JMP_JMS    = 1'b0;
    endtask

    task automatic ack();
        @(negedge CLK);
        INT_ACK = 1'b1;
        @(negedge CLK);
        INT_ACK = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Scoreboard monitor: every cycle a strobe is up must match a queued entry
    always @(negedge CLK) begin
        if (RESET_N && (SKIP || AC_LOAD || LINK_LOAD || DEV_CLR)) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe cyc=%0d: got skip=%b acl=%b aco=%o lkl=%b lko=%b clr=%b, expected none",
                         cyc, SKIP, AC_LOAD, AC_OUT, LINK_LOAD, LINK_OUT, DEV_CLR);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.cyc != cyc || e.skip !== SKIP || e.ac_load !== AC_LOAD ||
                    e.ac_out !== AC_OUT || e.link_load !== LINK_LOAD ||
                    e.link_out !== LINK_OUT || e.dev_clr !== DEV_CLR) begin
                    n_fail++;
                    $display("FAIL %s: got cyc=%0d skip=%b acl=%b aco=%o lkl=%b lko=%b clr=%b, expected cyc=%0d skip=%b acl=%b aco=%o lkl=%b lko=%b clr=%b",
                             e.name, cyc, SKIP, AC_LOAD, AC_OUT, LINK_LOAD, LINK_OUT, DEV_CLR,
                             e.cyc, e.skip, e.ac_load, e.ac_out, e.link_load, e.link_out,
                             e.dev_clr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("reset_outputs", {7'd0, IF, DF, INT_REQ, ION, SKIP, AC_LOAD, AC_OUT,
                              LINK_LOAD, LINK_OUT, DEV_CLR}, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // ION delay: no request at ION's own boundary, request one later
        IRQ = 4'b0001;
        iot(0, 12'o6001, 12'o0);
        chk("ion_set", ION, 1);
        idone(0);
        chk("ion_boundary_noreq", INT_REQ, 0);
        idone(0);
        chk("nop_boundary_req", INT_REQ, 1);
        ack();
        chk("ack_clears_req", INT_REQ, 0);
        chk("ack_clears_ion", ION, 0);
        IRQ = '0;

        // CDF 20, CIF 30, ION, TAD, JMP
        iot(1, 12'o6221, 12'o0);
        chk("cdf_df", DF, 2);
        idone(0);
        iot(2, 12'o6232, 12'o0);
        chk("cif_if_unchanged", IF, 0);
        idone(0);
        iot(0, 12'o6001, 12'o0);
        idone(0);
        IRQ = 4'b0100;
        idone(0);
        chk("tad_if_still0", IF, 0);
        chk("tad_ii_blocks_req", INT_REQ, 0);
        idone(1);
        chk("jmp_if", IF, 3);
        chk("jmp_boundary_noreq", INT_REQ, 0);
        idone(0);
        chk("after_jmp_req", INT_REQ, 1);
        iot(1, 12'o6251, 12'o0);
        chk("cdf_df5", DF, 5);
        ack();
        chk("ack_if0", IF, 0);
        chk("ack_df0", DF, 0);
        chk("ack_ion0", ION, 0);
        IRQ = '0;

        // RIB, RMF+JMP, RIF, RDF, undefined 62x4
        expect_strobe("rib", 0, 1, 12'o0035, 0, 0, 0);
        iot(4, 12'o6234, 12'o0000);
        iot(4, 12'o6244, 12'o7777);
        chk("rmf_df", DF, 5);
        chk("rmf_if_unchanged", IF, 0);
        idone(1);
        chk("rmf_jmp_if", IF, 3);
        expect_strobe("rif", 0, 1, 12'o0031, 0, 0, 0);
        iot(4, 12'o6224, 12'o0001);
        expect_strobe("rdf", 0, 1, 12'o0150, 0, 0, 0);
        iot(4, 12'o6214, 12'o0100);
        iot(4, 12'o6254, 12'o1234);
        chk("nop62x4_df", DF, 5);
        idone(0);

        // GTF, RTF
        iot(0, 12'o6001, 12'o0);
        idone(0);
        LINK = 1'b1;
        expect_strobe("gtf", 0, 1, 12'o4235, 0, 0, 0);
        iot(0, 12'o6004, 12'o0);
        LINK = 1'b0;
        expect_strobe("rtf", 0, 0, 12'o0, 1, 1, 0);
        iot(0, 12'o6005, 12'o4017);
        chk("rtf_df", DF, 7);
        chk("rtf_ion", ION, 1);
        IRQ = 4'b1000;
        idone(1);
        chk("rtf_jmp_if", IF, 1);
        chk("rtf_delay_noreq", INT_REQ, 0);
        idone(0);
        chk("rtf_next_req", INT_REQ, 1);

        // CAF while request pending
        expect_strobe("caf", 0, 1, 12'o0, 1, 0, 1);
        iot(0, 12'o6007, 12'o1234);
        chk("caf_req0", INT_REQ, 0);
        chk("caf_ion0", ION, 0);
        chk("caf_fields", {IF, DF}, 6'o17);
        IRQ = '0;
        idone(0);

        // SKON, SRQ, SGT, IOF, no-group DONE
        iot(0, 12'o6001, 12'o0);
        idone(0);
        expect_strobe("skon", 1, 0, 12'o0, 0, 0, 0);
        iot(0, 12'o6000, 12'o0);
        chk("skon_ie0", ION, 0);
        iot(0, 12'o6000, 12'o0);
        iot(0, 12'o6003, 12'o0);
        IRQ = 4'b0010;
        expect_strobe("srq_irq", 1, 0, 12'o0, 0, 0, 0);
        iot(0, 12'o6003, 12'o0);
        iot(0, 12'o6006, 12'o0);
        IRQ = '0;
        iot(0, 12'o6001, 12'o0);
        iot(0, 12'o6002, 12'o0);
        chk("iof_ie0", ION, 0);
        iot(9, 12'o6001, 12'o0);
        chk("nogroup_ion", ION, 0);
        chk("nogroup_fields", {IF, DF}, 6'o17);
        idone(0);

        @(negedge CLK);
        @(negedge CLK);
        chk("sb_drained", sb.size(), 0);

        // Async reset mid-sequence
        iot(2, 12'o6232, 12'o0);
        idone(1);
        iot(0, 12'o6001, 12'o0);
        idone(0);
        IRQ = 4'b0001;
        idone(0);
        chk("pre_reset_state", {INT_REQ, IF}, 4'b1011);
        #1;
        RESET_N = 1'b0;
        #1;
        chk("async_reset_outputs", {7'd0, IF, DF, INT_REQ, ION, SKIP, AC_LOAD, AC_OUT,
                                    LINK_LOAD, LINK_OUT, DEV_CLR}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
